// File: rtl/mm_score_ctrl.sv
// -----------------------------------------------------------------------------
// mm_score_ctrl
//
// Game-flow controller for the MasterMind score path.  It sits between the
// guess comparator and the hex score displays.  It accepts one scored guess
// per round over a valid/ready handshake, counts rounds, and decides whether
// the game is won or lost.  In the WIN state it also drives a blink/blank
// control for the displays.
//
// Optional feature (compile-time macro): MM_BEST_SCORE_EN
//   defined   : best_round keeps the fewest rounds needed for any win since
//               the last reset.
//   undefined : best_round is tied to 0 and no history register is built.
//
// Parameters
//   MAX_ROUNDS  rounds allowed before a loss (1..15)
//   CODE_LEN    pegs per code; a win is exact == CODE_LEN (1..7)
//   BLINK_DIV   clock cycles per blink half-period while in WIN (>= 2)
//
// Ports
//   clk            system clock
//   reset          synchronous, active-low reset
//   start          single-cycle pulse that begins a new game
//   res_valid      comparator has a scored guess
//   res_exact      correct colour, correct position
//   res_partial    correct colour, wrong position
//   res_ready      controller can accept a result (high only in PLAY)
//   exact_score    clamped exact count, to a single-digit display
//   partial_score  clamped partial count, to a single-digit display
//   round_score    rounds played, to a two-digit display
//   win            game won
//   lose           game lost
//   disp_blank     forces the displays to blank (blinks while in WIN)
//   best_round     fewest rounds to a win (0 when the feature is disabled)
// -----------------------------------------------------------------------------
module mm_score_ctrl #(
    parameter int MAX_ROUNDS = 10,
    parameter int CODE_LEN   = 4,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       res_valid,
    input  logic [2:0] res_exact,
    input  logic [2:0] res_partial,
    output logic       res_ready,
    output logic [3:0] exact_score,
    output logic [3:0] partial_score,
    output logic [4:0] round_score,
    output logic       win,
    output logic       lose,
    output logic       disp_blank,
    output logic [4:0] best_round
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int              CNT_W      = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_DIV - 1);
    localparam logic [3:0]      CODE_LEN_V = 4'(CODE_LEN);
    localparam logic [4:0]      MAX_RND_V  = 5'(MAX_ROUNDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t           state_q;
    logic [3:0]       exact_q;
    logic [3:0]       partial_q;
    logic [4:0]       round_q;
    logic             win_q;
    logic             lose_q;
    logic             blank_q;
    logic [CNT_W-1:0] blink_cnt_q;

    // Next values for the captured scores (clamped comparator result)
    logic [3:0] exact_d;
    logic [3:0] partial_d;
    logic [4:0] round_d;

    // Intermediate terms of the clamp
    logic [3:0] exact_ext;
    logic [3:0] partial_ext;
    logic [3:0] partial_room;

    // Win decision is made from the registered exact score during CHECK
    logic win_now;

    // -------------------------------------------------------------------------
    // Result clamping
    // A misbehaving comparator could report more pegs than exist.  Exact is
    // limited to CODE_LEN, and partial is limited to the pegs exact left over,
    // so exact + partial never exceeds CODE_LEN on the displays.
    // -------------------------------------------------------------------------
    always_comb begin
        exact_ext    = {1'b0, res_exact};
        partial_ext  = {1'b0, res_partial};
        exact_d      = (exact_ext > CODE_LEN_V) ? CODE_LEN_V : exact_ext;
        partial_room = CODE_LEN_V - exact_d;
        partial_d    = (partial_ext > partial_room) ? partial_room : partial_ext;
    end

    // Round counter saturates at MAX_ROUNDS; it must never wrap back to a
    // small value that would let the game continue.
    always_comb begin
        round_d = (round_q < MAX_RND_V) ? (round_q + 5'd1) : round_q;
    end

    assign win_now = (state_q == ST_CHECK) && (exact_q == CODE_LEN_V);

    // Ready is a pure function of state so the comparator sees it without an
    // extra cycle of delay; CHECK drops it so a held valid is consumed once.
    assign res_ready = (state_q == ST_PLAY);

    // -------------------------------------------------------------------------
    // Game-flow FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            exact_q     <= '0;
            partial_q   <= '0;
            round_q     <= '0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            blank_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_PLAY;
                        exact_q   <= '0;
                        partial_q <= '0;
                        round_q   <= '0;
                    end
                end

                ST_PLAY: begin
                    // start is ignored here; only the handshake advances.
                    if (res_valid) begin
                        exact_q   <= exact_d;
                        partial_q <= partial_d;
                        round_q   <= round_d;
                        state_q   <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    // A win on the last allowed round still counts as a win.
                    if (win_now) begin
                        state_q     <= ST_WIN;
                        win_q       <= 1'b1;
                        blank_q     <= 1'b0;
                        blink_cnt_q <= '0;
                    end else if (round_q == MAX_RND_V) begin
                        state_q <= ST_LOSE;
                        lose_q  <= 1'b1;
                        blank_q <= 1'b0;
                    end else begin
                        state_q <= ST_PLAY;
                    end
                end

                ST_WIN: begin
                    if (start) begin
                        state_q     <= ST_PLAY;
                        exact_q     <= '0;
                        partial_q   <= '0;
                        round_q     <= '0;
                        win_q       <= 1'b0;
                        lose_q      <= 1'b0;
                        blank_q     <= 1'b0;
                        blink_cnt_q <= '0;
                    end else if (blink_cnt_q == CNT_LAST) begin
                        // End of a half-period: wrap and flip the blank phase.
                        blink_cnt_q <= '0;
                        blank_q     <= ~blank_q;
                    end else begin
                        blink_cnt_q <= blink_cnt_q + 1'b1;
                    end
                end

                ST_LOSE: begin
                    if (start) begin
                        state_q     <= ST_PLAY;
                        exact_q     <= '0;
                        partial_q   <= '0;
                        round_q     <= '0;
                        win_q       <= 1'b0;
                        lose_q      <= 1'b0;
                        blank_q     <= 1'b0;
                        blink_cnt_q <= '0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign exact_score   = exact_q;
    assign partial_score = partial_q;
    assign round_score   = round_q;
    assign win           = win_q;
    assign lose          = lose_q;
    assign disp_blank    = blank_q;

    // -------------------------------------------------------------------------
    // Best-round history
    // Updated on the CHECK->WIN transition, when round_q already holds the
    // winning round.  Only reset clears it so it survives across games.
    // -------------------------------------------------------------------------
`ifdef MM_BEST_SCORE_EN
    logic [4:0] best_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            best_q <= '0;
        end else if (win_now && ((best_q == 5'd0) || (round_q < best_q))) begin
            best_q <= round_q;
        end
    end

    assign best_round = best_q;
`else
    assign best_round = 5'd0;
`endif

endmodule

// File: tb/tb_mm_score_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mm_score_ctrl
//
// Directed testbench for mm_score_ctrl with MAX_ROUNDS=10, CODE_LEN=4 and a
// short BLINK_DIV=4 so the blink behaviour is visible in a few cycles.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mm_score_ctrl;

    localparam int MAX_ROUNDS = 10;
    localparam int CODE_LEN   = 4;
    localparam int BLINK_DIV  = 4;

`ifdef MM_BEST_SCORE_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic       res_valid;
    logic [2:0] res_exact;
    logic [2:0] res_partial;
    logic       res_ready;
    logic [3:0] exact_score;
    logic [3:0] partial_score;
    logic [4:0] round_score;
    logic       win;
    logic       lose;
    logic       disp_blank;
    logic [4:0] best_round;

    int compared   = 0;
    int mismatched = 0;

    mm_score_ctrl #(
        .MAX_ROUNDS (MAX_ROUNDS),
        .CODE_LEN   (CODE_LEN),
        .BLINK_DIV  (BLINK_DIV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .res_valid     (res_valid),
        .res_exact     (res_exact),
        .res_partial   (res_partial),
        .res_ready     (res_ready),
        .exact_score   (exact_score),
        .partial_score (partial_score),
        .round_score   (round_score),
        .win           (win),
        .lose          (lose),
        .disp_blank    (disp_blank),
        .best_round    (best_round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ready"},   32'(res_ready),     32'd0);
        check({tag, ".exact"},   32'(exact_score),   32'd0);
        check({tag, ".partial"}, 32'(partial_score), 32'd0);
        check({tag, ".round"},   32'(round_score),   32'd0);
        check({tag, ".win"},     32'(win),           32'd0);
        check({tag, ".lose"},    32'(lose),          32'd0);
        check({tag, ".blank"},   32'(disp_blank),    32'd0);
        check({tag, ".best"},    32'(best_round),    32'd0);
    endtask

    // One start pulse; the controller must be in PLAY with cleared scores.
    task automatic new_game(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".ready"}, 32'(res_ready),   32'd1);
        check({tag, ".round"}, 32'(round_score), 32'd0);
        check({tag, ".win"},   32'(win),         32'd0);
        check({tag, ".lose"},  32'(lose),        32'd0);
        check({tag, ".blank"}, 32'(disp_blank),  32'd0);
    endtask

    // One handshake from PLAY; checks captured scores, then steps through CHECK.
    task automatic play_round(input string tag, input logic [2:0] e, input logic [2:0] p,
                              input logic [3:0] exp_e, input logic [3:0] exp_p,
                              input logic [4:0] exp_r);
        res_valid   = 1'b1;
        res_exact   = e;
        res_partial = p;
        tick();
        res_valid = 1'b0;
        check({tag, ".exact"},   32'(exact_score),   32'(exp_e));
        check({tag, ".partial"}, 32'(partial_score), 32'(exp_p));
        check({tag, ".round"},   32'(round_score),   32'(exp_r));
        check({tag, ".chk_rdy"}, 32'(res_ready),     32'd0);
        tick();
    endtask

    initial begin
        logic [4:0] best_exp;
        logic [4:0] targets [3];

        reset       = 1'b0;
        start       = 1'b0;
        res_valid   = 1'b0;
        res_exact   = '0;
        res_partial = '0;

        // ---------------- reset and start ----------------
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();
        check_all_zero("idle");
        // res_valid in IDLE is not acknowledged
        res_valid = 1'b1;
        res_exact = 3'd4;
        tick();
        res_valid = 1'b0;
        check_all_zero("idle_valid");
        new_game("start1");

        // ---------------- immediate win and blink ----------------
        play_round("win1", 3'd4, 3'd0, 4'd4, 4'd0, 5'd1);
        check("win1.win",   32'(win),        32'd1);
        check("win1.lose",  32'(lose),       32'd0);
        check("win1.blank", 32'(disp_blank), 32'd0);
        check("win1.ready", 32'(res_ready),  32'd0);
        res_valid = 1'b1;            // ignored in WIN
        tick(); tick(); tick();
        check("blink.c3", 32'(disp_blank), 32'd0);
        check("blink.rnd", 32'(round_score), 32'd1);
        check("blink.rdy", 32'(res_ready),   32'd0);
        res_valid = 1'b0;
        tick();
        check("blink.c4", 32'(disp_blank), 32'd1);
        tick(); tick(); tick();
        check("blink.c7", 32'(disp_blank), 32'd1);
        tick();
        check("blink.c8", 32'(disp_blank), 32'd0);
        check("blink.win", 32'(win),       32'd1);

        // ---------------- loss after MAX_ROUNDS ----------------
        new_game("start2");
        for (int i = 1; i <= MAX_ROUNDS; i++) begin
            play_round("loss", 3'd2, 3'd1, 4'd2, 4'd1, 5'(i));
            if (i == 3) begin
                start = 1'b1;        // ignored in PLAY
                tick();
                start = 1'b0;
                check("ign_start.round", 32'(round_score), 32'd3);
                check("ign_start.ready", 32'(res_ready),   32'd1);
            end
        end
        check("loss.lose",  32'(lose),       32'd1);
        check("loss.win",   32'(win),        32'd0);
        check("loss.blank", 32'(disp_blank), 32'd0);
        res_valid = 1'b1;
        tick();
        check("loss11.ready", 32'(res_ready),   32'd0);
        tick();
        check("loss11.round", 32'(round_score), 32'd10);
        check("loss11.ready2", 32'(res_ready),  32'd0);
        res_valid = 1'b0;

        // ---------------- clamp ----------------
        new_game("start3");
        play_round("clamp", 3'd7, 3'd3, 4'd4, 4'd0, 5'd1);
        check("clamp.win", 32'(win), 32'd1);

        // ---------------- partial clamp and win-on-last-round priority ----------------
        new_game("start4");
        play_round("pclamp", 3'd2, 3'd5, 4'd2, 4'd2, 5'd1);
        for (int i = 2; i <= MAX_ROUNDS - 1; i++) begin
            play_round("mid", 3'd1, 3'd0, 4'd1, 4'd0, 5'(i));
        end
        play_round("last", 3'd4, 3'd0, 4'd4, 4'd0, 5'd10);
        check("prio.win",  32'(win),  32'd1);
        check("prio.lose", 32'(lose), 32'd0);

        // ---------------- held valid (backpressure) and mid-game reset ----------------
        new_game("start5");
        res_valid   = 1'b1;
        res_exact   = 3'd1;
        res_partial = 3'd1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("hold.chk_round", 32'(round_score), 32'(i));
            check("hold.chk_ready", 32'(res_ready),   32'd0);
            if (i < 5) begin
                tick();
                check("hold.play_round", 32'(round_score), 32'(i));
                check("hold.play_ready", 32'(res_ready),   32'd1);
            end
        end
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_all_zero("midreset");
        reset     = 1'b1;
        res_valid = 1'b0;
        tick();
        check_all_zero("midreset_idle");

        // ---------------- best round history ----------------
        targets[0] = 5'd6;
        targets[1] = 5'd3;
        targets[2] = 5'd8;
        best_exp   = 5'd0;
        for (int g = 0; g < 3; g++) begin
            new_game("start_best");
            for (int r = 1; r < int'(targets[g]); r++) begin
                play_round("best_miss", 3'd0, 3'd0, 4'd0, 4'd0, 5'(r));
            end
            play_round("best_hit", 3'd4, 3'd0, 4'd4, 4'd0, targets[g]);
            check("best.win", 32'(win), 32'd1);
            if (best_exp == 5'd0 || targets[g] < best_exp) best_exp = targets[g];
            check("best.value", 32'(best_round), BEST_EN ? 32'(best_exp) : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mm_score_ctrl.md
Name: mm_score_ctrl

Overview:
- Game-flow controller for the MasterMind score path. It sits between the guess comparator and the hex score displays.
- Accepts one scored guess per round over a valid/ready handshake and counts rounds.
- Decides win/loss and sequences the values presented to the single-digit and two-digit score display decoders. In the WIN state it also drives a blink/blank control.

Parameters:
- MAX_ROUNDS, 10, rounds allowed before loss; legal 1..15.
- CODE_LEN, 4, pegs per code; a win occurs when exact == CODE_LEN; legal 1..7.
- BLINK_DIV, 25000000, clock cycles per blink half-period in WIN; minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- start  input  1  single-cycle pulse that begins a new game
- res_valid  input  1  comparator has a scored guess
- res_exact  input  3  correct colour, correct position
- res_partial  input  3  correct colour, wrong position
- res_ready  output  1  controller can accept a result
- exact_score  output  4  to single-digit display
- partial_score  output  4  to single-digit display
- round_score  output  5  to two-digit display
- win  output  1  game won
- lose  output  1  game lost
- disp_blank  output  1  forces the displays to blank
- best_round  output  5  fewest rounds to a win (optional feature)

Behaviour:
- Reset: sampled on a rising clk edge with reset==0. Next state is IDLE. All outputs become 0, including best_round. The blink counter clears. Reset overrides start and res_valid in the same cycle, and aborts any game in progress.
- States: IDLE, PLAY, CHECK, WIN, LOSE. Outputs are registered and update on the clk edge after the causing event.
- IDLE:
  - res_ready=0.
  - start=1 -> PLAY; exact_score, partial_score and round_score clear to 0.
- PLAY:
  - res_ready=1 (combinational from state).
  - Handshake fires on res_valid && res_ready. Next edge: capture the clamped exact/partial values, round_score += 1, -> CHECK.
  - res_valid held with no transfer keeps waiting indefinitely; no timeout.
- Clamping (width rule):
  - exact_c = min(res_exact, CODE_LEN).
  - partial_c = min(res_partial, CODE_LEN - exact_c).
  - Both are zero-extended to 4 bits.
- CHECK:
  - Lasts exactly one cycle; res_ready=0, so a held res_valid is not consumed twice.
  - exact_score == CODE_LEN -> WIN. Win takes priority when it coincides with round_score == MAX_ROUNDS.
  - Otherwise round_score == MAX_ROUNDS -> LOSE.
  - Otherwise -> PLAY.
- round_score saturates at MAX_ROUNDS and never wraps.
- WIN:
  - win=1; scores are held.
  - The blink counter counts 0..BLINK_DIV-1; disp_blank toggles on each wrap, starting at 0 on WIN entry.
- LOSE:
  - lose=1; scores are held; disp_blank=0.
- start in WIN or LOSE -> PLAY:
  - All scores clear; win, lose and disp_blank clear; the blink counter clears.
- start while in PLAY or CHECK is ignored.
- res_valid outside PLAY is ignored and never acknowledged.
- Latency: handshake -> scores visible 1 cycle; handshake -> win/lose asserted 2 cycles.

Optional Feature:
- Macro: MM_BEST_SCORE_EN.
- Defined:
  - On entering WIN, best_round is updated to round_score if best_round == 0 or round_score < best_round.
  - best_round is cleared only by reset, never by start.
- Undefined:
  - best_round is tied to 0 and no history register is built.

Test Plan:
- Reset and start: hold reset=0 for 2 cycles, release, pulse start -> all outputs 0 in IDLE; state is PLAY and res_ready=1 the cycle after start.
- Immediate win: in round 1 send exact=4, partial=0 -> exact_score=4, round_score=1 next cycle; win=1 the cycle after. disp_blank toggles every BLINK_DIV cycles (set BLINK_DIV=4 in the bench).
- Loss: send 10 results of exact=2, partial=1 -> round_score counts 1..10 then stops; lose=1 after the 10th; an 11th res_valid gets no res_ready.
- Clamp and priority:
  - Send exact=7, partial=3 -> exact_score=4, partial_score=0, win=1.
  - In round 10 send exact=4 -> win=1, lose=0.
- Backpressure and mid-game reset:
  - Hold res_valid high through CHECK -> exactly one round counted per PLAY visit.
  - Assert reset=0 mid-game at round 5 -> next cycle IDLE and all outputs 0.
- MM_BEST_SCORE_EN: win in round 6, restart, win in round 3, restart, win in round 8 -> best_round reads 6, 3, 3. Without the macro, best_round stays 0 throughout.
